// File: rtl/audio_mix_sched_if.sv
// audio_mix_sched_if: sample handshakes from the two audio sources
// (A = sound generator, B = speech) into the mixer/scheduler.
// master = upstream sources, slave = audio_mix_sched.
interface audio_mix_sched_if #(
   parameter int AUDIO_BITS = 16
);
   logic [AUDIO_BITS-1:0] a_data;
   logic                  a_valid;
   logic                  a_ready;
   logic [AUDIO_BITS-1:0] b_data;
   logic                  b_valid;
   logic                  b_ready;

   modport master (
      output a_data, a_valid, b_data, b_valid,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_data, a_valid, b_data, b_valid,
      output a_ready, b_ready
   );
endinterface

// File: rtl/audio_mix_sched.sv
// audio_mix_sched: paces two audio sources to a fixed sample tick, mixes
// them with saturation and applies mute gain before the sigma-delta DAC.
// Optional feature macro: AUDIO_SOFTMUTE_EN
//   defined   -> gain ramps 0..2^GAIN_BITS one step per tick (click-free)
//   undefined -> hard mute, d is either the mix or 0, no multiplier
module audio_mix_sched #(
   parameter int AUDIO_BITS = 16,
   parameter int CLK_DIV    = 256,
   parameter int GAIN_BITS  = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   audio_mix_sched_if.slave      src,
   output logic [AUDIO_BITS-1:0] d,
   output logic                  tick,
   output logic                  muted,
   output logic                  clip,
   output logic [1:0]            underrun
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AUDIO_BITS-1:0] MAXV = {1'b0, {(AUDIO_BITS-1){1'b1}}};
   localparam logic [AUDIO_BITS-1:0] MINV = {1'b1, {(AUDIO_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Sample tick divider
   // ------------------------------------------------------------------
   logic [CW-1:0] cnt;

   // free-running 0..CLK_DIV-1 counter; tick is its terminal count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                     cnt <= cnt + CNT_ONE;
   end

   assign tick = (cnt == CNT_LAST);

   // ------------------------------------------------------------------
   // Per-source holding register, full flag and last-value (hold) reg
   // ------------------------------------------------------------------
   logic [1:0][AUDIO_BITS-1:0] s_data;
   logic [1:0][AUDIO_BITS-1:0] s_cur;
   logic [1:0]                 s_valid;
   logic [1:0]                 s_ready;
   logic [1:0]                 full;

   assign s_data  = {src.b_data, src.a_data};
   assign s_valid = {src.b_valid, src.a_valid};
   assign src.a_ready = s_ready[0];
   assign src.b_ready = s_ready[1];

   for (genvar g = 0; g < 2; g++) begin : g_src
      logic [AUDIO_BITS-1:0] hold_r;
      logic [AUDIO_BITS-1:0] last_r;
      logic                  full_r;
      logic                  xfer;

      // the tick consumes the held sample, so a new one may enter that cycle
      assign s_ready[g] = !full_r || tick;
      assign xfer       = s_valid[g] && s_ready[g];
      // an empty register at tick falls back to sample-and-hold
      assign s_cur[g]   = full_r ? hold_r : last_r;
      assign full[g]    = full_r;

      // load on handshake; a tick-cycle load is kept for the next tick
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            hold_r <= '0;
            last_r <= '0;
            full_r <= 1'b0;
         end else begin
            if (xfer) begin
               hold_r <= s_data[g];
               full_r <= 1'b1;
            end else if (tick) begin
               full_r <= 1'b0;
            end
            if (tick && full_r) last_r <= hold_r;
         end
      end
   end

   // ------------------------------------------------------------------
   // Saturating mix
   // ------------------------------------------------------------------
   logic [AUDIO_BITS:0]   sum;
   logic                  sat;
   logic [AUDIO_BITS-1:0] mix;

   // one guard bit is enough for two operands; disagreeing top bits = overflow
   always_comb begin
      sum = {s_cur[0][AUDIO_BITS-1], s_cur[0]} + {s_cur[1][AUDIO_BITS-1], s_cur[1]};
      sat = sum[AUDIO_BITS] ^ sum[AUDIO_BITS-1];
      mix = sum[AUDIO_BITS-1:0];
      if (sat) mix = sum[AUDIO_BITS] ? MINV : MAXV;
   end

   // ------------------------------------------------------------------
   // Gain and output register
   // ------------------------------------------------------------------
   state_t                state;
   logic [AUDIO_BITS-1:0] out_val;

`ifdef AUDIO_SOFTMUTE_EN
   localparam logic [GAIN_BITS:0] GFULL = {1'b1, {GAIN_BITS{1'b0}}};
   localparam logic [GAIN_BITS:0] GONE  = {{GAIN_BITS{1'b0}}, 1'b1};

   logic [GAIN_BITS:0]                 gain;
   logic [GAIN_BITS:0]                 g_up;
   logic [GAIN_BITS:0]                 g_dn;
   logic signed [AUDIO_BITS+GAIN_BITS+1:0] prod;

   assign g_up = gain + GONE;
   assign g_dn = gain - GONE;
   // gain is unsigned 0..2^GAIN_BITS; >>> floors toward -inf
   assign prod    = $signed(mix) * $signed({1'b0, gain});
   assign out_val = AUDIO_BITS'(prod >>> GAIN_BITS);

   // tick-paced output update and ramped-gain FSM; gain used is pre-step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= MUTED;
         gain     <= '0;
         d        <= '0;
         muted    <= 1'b1;
         clip     <= 1'b0;
         underrun <= '0;
      end else begin
         clip     <= 1'b0;
         underrun <= '0;
         if (tick) begin
            d        <= out_val;
            clip     <= sat;
            underrun <= ~full;
            case (state)
               MUTED: if (enable) begin
                  gain  <= g_up;
                  state <= (g_up == GFULL) ? RUN : RAMP_UP;
                  muted <= 1'b0;
               end
               RAMP_UP, RAMP_DOWN: begin
                  if (enable) begin
                     gain  <= g_up;
                     state <= (g_up == GFULL) ? RUN : RAMP_UP;
                  end else begin
                     gain <= g_dn;
                     if (g_dn == '0) begin
                        state <= MUTED;
                        muted <= 1'b1;
                     end else begin
                        state <= RAMP_DOWN;
                     end
                  end
               end
               RUN: if (!enable) begin
                  gain  <= g_dn;
                  state <= RAMP_DOWN;
               end
               default: begin
                  state <= MUTED;
                  gain  <= '0;
                  muted <= 1'b1;
               end
            endcase
         end
      end
   end
`else
   // hard mute: enable seen at the tick switches that very update
   assign out_val = enable ? mix : '0;

   // tick-paced output update and two-state mute FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= MUTED;
         d        <= '0;
         muted    <= 1'b1;
         clip     <= 1'b0;
         underrun <= '0;
      end else begin
         clip     <= 1'b0;
         underrun <= '0;
         if (tick) begin
            d        <= out_val;
            clip     <= sat;
            underrun <= ~full;
            case (state)
               MUTED: if (enable) begin
                  state <= RUN;
                  muted <= 1'b0;
               end
               RUN: if (!enable) begin
                  state <= MUTED;
                  muted <= 1'b1;
               end
               default: begin
                  state <= MUTED;
                  muted <= 1'b1;
               end
            endcase
         end
      end
   end
`endif

endmodule

// File: doc/audio_mix_sched.md
# audio_mix_sched

Audio sample scheduler and soft-mute controller feeding the first-order sigma-delta DAC. Accepts samples from two independent sources (sound generator, speech) over valid/ready handshakes. Paces them to a fixed sample tick derived from the system clock and mixes them with saturation. A ramped gain applies click-free mute/unmute, and the block presents a registered signed word on `d` for the DAC.

## Interface
- `audio_bits`, 16: sample width, all data signed two's complement (DAC offsets MSB itself).
- `clk_div`, 256: clocks per sample tick, >= 2.
- `gain_bits`, 6: gain resolution; full-scale gain = 2^gain_bits.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = unmute request, 0 = mute request; level-sensitive.
- `a_data`  in  audio_bits  source A sample.
- `a_valid`  in  1  source A sample offered.
- `a_ready`  out  1  source A holding register can accept.
- `b_data` / `b_valid` / `b_ready`: same as A, for source B.
- `d`  out  audio_bits  registered mixed sample to DAC.
- `tick`  out  1  one-cycle pulse at each sample instant.
- `muted`  out  1  1 while gain is 0 in MUTED state.
- `clip`  out  1  one-cycle pulse, mix saturated on this update.
- `underrun`  out  2  one-cycle pulse per source ([0]=A, [1]=B): holding register empty at tick.

## Operation
- Divider counts 0..clk_div-1 and wraps; `tick`=1 in the cycle the count equals clk_div-1.
- Per source: holding register plus full flag, and a last-value register.
  - `x_ready` = !full || tick.
  - Transfer on valid && ready loads the holding register and sets full.
- At tick, per source:
  - If full: the mix uses the holding value, copies it to last-value, and clears full unless a transfer occurs in the same cycle.
  - If empty: the mix reuses last-value (sample-and-hold) and pulses the `underrun` bit.
  - A transfer in the tick cycle does not feed that tick. It becomes the next tick's sample.
- Mix: sign-extend both to audio_bits+1, add, then saturate to [-2^(audio_bits-1), 2^(audio_bits-1)-1]. Pulse `clip` when limited.
- Gain: product of saturated mix and gain (0..2^gain_bits), arithmetic shift right by gain_bits, truncate toward negative infinity. Full gain passes the mix unchanged.
- Gain FSM, evaluated only on tick:
  - MUTED: gain 0; enable=1 -> RAMP_UP.
  - RAMP_UP: gain+1 per tick; reaching 2^gain_bits -> RUN; enable=0 -> RAMP_DOWN from current gain.
  - RUN: enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain-1 per tick; reaching 0 -> MUTED; enable=1 -> RAMP_UP from current gain.
- Sources are drained in every state, including MUTED, so upstream never stalls.
- Reset (asynchronous, any time including mid-ramp):
  - `d`=0, `tick`=0, `muted`=1, `clip`=0, `underrun`=0.
  - Counter 0, gain 0, state MUTED, full flags 0, last-values 0.
  - `x_ready`=1 after reset.

## Timing
- `d`, `clip`, `underrun` and the gain/state update in the cycle after `tick`.
- Gain used for a tick is the value before that tick's FSM step.
- Ticks are spaced exactly clk_div cycles apart; first tick at cycle clk_div-1 after reset release.
- Ramp duration is 2^gain_bits ticks from full to 0 or 0 to full.
- `muted` updates together with `d`.
- The handshake is single-cycle: a source may present back-to-back valid. At most one sample is buffered between ticks.

## Configuration
- `AUDIO_SOFTMUTE_EN` defined: ramped gain FSM as above.
- Undefined:
  - Gain is 0 or 2^gain_bits only; FSM is MUTED/RUN.
  - enable is sampled at tick and the switch is immediate on that tick's update.
  - The multiplier is omitted; `d` is the mix or 0.

## Test plan
All scenarios use clk_div=4, gain_bits=2, audio_bits=16.
- Reset release: no inputs -> `tick` first at cycle 3, then every 4 cycles; `d`=0 and `muted`=1 throughout; `underrun`=2'b11 each tick.
- Soft-mute ramp: enable=1, A=0x1000 held valid, B=0 -> successive `d` = 0, 0x0400, 0x0800, 0x0C00, 0x1000; `muted` drops after first step. Reversing to enable=0 at gain 2 -> next `d` 0x0800 then 0x0400, 0, `muted`=1.
- Saturation: in RUN, A=0x7000, B=0x2000 -> `d`=0x7FFF, `clip` pulse. A=0x9000, B=0xA000 -> `d`=0x8000, `clip` pulse.
- Handshake on tick: A valid with new value arriving exactly on the tick cycle while full -> `a_ready`=1, old value mixed, new value mixed at the following tick, no underrun.
- Underrun hold: A supplies 0x0100 once then stops -> later ticks keep mixing 0x0100 with `underrun[0]` pulsing.
- Reset mid-ramp: assert reset_n=0 during RAMP_UP -> `d`=0 and `muted`=1 immediately (asynchronously). After release, ramp restarts from gain 0.
